// File: rtl/cached_fetcher_pkg.sv
// Shared encodings for the cached fetcher: fetcher states seen by the scheduler
// and the core states the fetcher reacts to.
package cached_fetcher_pkg;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_e;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

endpackage

// File: rtl/cached_fetcher_fetch_line_store.sv
// Direct-mapped one-word line store: valid/tag/data arrays with a combinational
// lookup, a synchronous fill port and a synchronous clear of all valid bits.
module fetch_line_store
  import cached_fetcher_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned TAG_BITS   = 5,
  parameter int unsigned DATA_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic [INDEX_BITS-1:0] i_lookup_index,
  input  logic [TAG_BITS-1:0]   i_lookup_tag,
  output logic                  o_hit_c,
  output logic [DATA_BITS-1:0]  o_data_c,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [TAG_BITS-1:0]   i_wr_tag,
  input  logic [DATA_BITS-1:0]  i_wr_data
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]     r_valid;
  logic [TAG_BITS-1:0]  r_tag  [LINES];
  logic [DATA_BITS-1:0] r_data [LINES];

  // Clear wins over a coincident fill, leaving the filled line invalid.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en && !i_clear) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_hit_c  = r_valid[i_lookup_index] && (r_tag[i_lookup_index] == i_lookup_tag);
  assign o_data_c = r_data[i_lookup_index];

endmodule

// File: rtl/cached_fetcher.sv
// Instruction fetcher with a direct-mapped one-word-per-line cache, bulk
// invalidate and saturating hit/miss profiling counters.
module cached_fetcher
  import cached_fetcher_pkg::*;
#(
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
  parameter int unsigned CACHE_LINES           = 8,
  parameter int unsigned COUNTER_BITS          = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             invalidate,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [COUNTER_BITS-1:0]          hit_count,
  output logic [COUNTER_BITS-1:0]          miss_count
);

  localparam int unsigned INDEX_BITS = $clog2(CACHE_LINES);
  localparam int unsigned TAG_BITS   = PROGRAM_MEM_ADDR_BITS - INDEX_BITS;

  fetcher_state_e                   r_state, w_state_nx;
  logic                             r_mem_read_valid, w_mem_read_valid_nx;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_mem_read_address, w_mem_read_address_nx;
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_instruction, w_instruction_nx;
  logic [COUNTER_BITS-1:0]          r_hit_count, w_hit_count_nx;
  logic [COUNTER_BITS-1:0]          r_miss_count, w_miss_count_nx;

  logic                             w_line_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] w_line_data;
  logic                             w_wr_en;

  // The latched request address doubles as the fill index/tag.
  fetch_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_BITS  (PROGRAM_MEM_DATA_BITS)
  ) u_line_store (
    .clk            (clk),
    .reset          (reset),
    .i_clear        (invalidate),
    .i_lookup_index (current_pc[INDEX_BITS-1:0]),
    .i_lookup_tag   (current_pc[PROGRAM_MEM_ADDR_BITS-1:INDEX_BITS]),
    .o_hit_c        (w_line_hit),
    .o_data_c       (w_line_data),
    .i_wr_en        (w_wr_en),
    .i_wr_index     (r_mem_read_address[INDEX_BITS-1:0]),
    .i_wr_tag       (r_mem_read_address[PROGRAM_MEM_ADDR_BITS-1:INDEX_BITS]),
    .i_wr_data      (mem_read_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= FETCHER_IDLE;
      r_mem_read_valid   <= 1'b0;
      r_mem_read_address <= '0;
      r_instruction      <= '0;
      r_hit_count        <= '0;
      r_miss_count       <= '0;
    end else begin
      r_state            <= w_state_nx;
      r_mem_read_valid   <= w_mem_read_valid_nx;
      r_mem_read_address <= w_mem_read_address_nx;
      r_instruction      <= w_instruction_nx;
      r_hit_count        <= w_hit_count_nx;
      r_miss_count       <= w_miss_count_nx;
    end
  end

  // Invalidate in the lookup cycle forces a miss.
  always_comb begin
    w_state_nx            = r_state;
    w_mem_read_valid_nx   = r_mem_read_valid;
    w_mem_read_address_nx = r_mem_read_address;
    w_instruction_nx      = r_instruction;
    w_hit_count_nx        = r_hit_count;
    w_miss_count_nx       = r_miss_count;
    w_wr_en               = 1'b0;
    case (r_state)
      FETCHER_IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (w_line_hit && !invalidate) begin
            w_instruction_nx = w_line_data;
            w_hit_count_nx   = (r_hit_count == '1) ? r_hit_count
                                                   : r_hit_count + COUNTER_BITS'(1);
            w_state_nx       = FETCHER_FETCHED;
          end else begin
            w_mem_read_valid_nx   = 1'b1;
            w_mem_read_address_nx = current_pc;
            w_miss_count_nx       = (r_miss_count == '1) ? r_miss_count
                                                         : r_miss_count + COUNTER_BITS'(1);
            w_state_nx            = FETCHER_FETCHING;
          end
        end
      end
      FETCHER_FETCHING: begin
        if (mem_read_ready) begin
          w_instruction_nx    = mem_read_data;
          w_mem_read_valid_nx = 1'b0;
          w_wr_en             = 1'b1;
          w_state_nx          = FETCHER_FETCHED;
        end
      end
      FETCHER_FETCHED: begin
        if (core_state == CORE_DECODE) begin
          w_state_nx = FETCHER_IDLE;
        end
      end
      default: w_state_nx = FETCHER_IDLE;
    endcase
  end

  assign fetcher_state    = 3'(r_state);
  assign mem_read_valid   = r_mem_read_valid;
  assign mem_read_address = r_mem_read_address;
  assign instruction      = r_instruction;
  assign hit_count        = r_hit_count;
  assign miss_count       = r_miss_count;

endmodule

// File: tb/tb_cached_fetcher.sv
// Scoreboard bench for cached_fetcher: a line-keyed reference cache predicts
// hit/miss, requests and counters; a monitor checks each delivered fetch.
module tb_cached_fetcher;
  import cached_fetcher_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        invalidate;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;

  logic        mem_read_valid, s_mem_read_valid;
  logic [7:0]  mem_read_address, s_mem_read_address;
  logic [2:0]  fetcher_state, s_fetcher_state;
  logic [15:0] instruction, s_instruction;
  logic [15:0] hit_count, miss_count;
  logic [1:0]  s_hit_count, s_miss_count;

  always #5 clk = ~clk;

  cached_fetcher u_dut (
    .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
    .invalidate(invalidate), .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address), .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data), .fetcher_state(fetcher_state),
    .instruction(instruction), .hit_count(hit_count), .miss_count(miss_count)
  );

  // Same stimulus, 2-bit counters to exercise saturation.
  cached_fetcher #(.COUNTER_BITS(2)) u_sat (
    .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
    .invalidate(invalidate), .mem_read_valid(s_mem_read_valid),
    .mem_read_address(s_mem_read_address), .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data), .fetcher_state(s_fetcher_state),
    .instruction(s_instruction), .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  typedef struct {
    logic [15:0] instr;
    int          hits;
    int          misses;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  addr_q[$];
  logic [15:0] mem [256];

  // Reference cache: which full pc each line currently holds.
  bit          m_valid [8];
  logic [7:0]  m_pc    [8];
  int          m_hits, m_misses;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endtask

  // Monitor: every new request and every delivered fetch is checked.
  logic prev_req = 1'b0;
  logic prev_fetched = 1'b0;
  always @(negedge clk) begin
    if (mem_read_valid && !prev_req) begin
      if (addr_q.size() == 0) check("spurious_mem_read", 32'(mem_read_address), 32'hFFFF);
      else check("mem_read_address", 32'(mem_read_address), 32'(addr_q.pop_front()));
    end
    if (fetcher_state == 3'(FETCHER_FETCHED) && !prev_fetched) begin
      if (exp_q.size() == 0) begin
        check("unexpected_fetched", 32'(fetcher_state), 32'(FETCHER_IDLE));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("instruction", 32'(instruction), 32'(e.instr));
        check("hit_count", 32'(hit_count), 32'(e.hits));
        check("miss_count", 32'(miss_count), 32'(e.misses));
        check("sat_hit_count", 32'(s_hit_count), 32'(sat3(e.hits)));
        check("sat_miss_count", 32'(s_miss_count), 32'(sat3(e.misses)));
        check("sat_instruction", 32'(s_instruction), 32'(e.instr));
      end
    end
    prev_req     = mem_read_valid;
    prev_fetched = (fetcher_state == 3'(FETCHER_FETCHED));
  end

  // One complete fetch: FETCH, optional memory service, then DECODE back to IDLE.
  task automatic do_fetch(input logic [7:0] pc, input int delay,
                          input bit inv_lookup, input bit inv_fill);
    int idx;
    bit hit;
    idx = int'(pc[2:0]);
    @(negedge clk);
    core_state     = CORE_FETCH;
    current_pc     = pc;
    invalidate     = inv_lookup;
    mem_read_ready = 1'($urandom_range(0, 1));
    mem_read_data  = 16'($urandom);
    if (inv_lookup) model_clear();
    hit = m_valid[idx] && (m_pc[idx] == pc);
    if (hit) m_hits++;
    else begin
      m_misses++;
      addr_q.push_back(pc);
    end
    exp_q.push_back('{instr: mem[pc], hits: m_hits, misses: m_misses});
    @(negedge clk);
    invalidate     = 1'b0;
    mem_read_ready = 1'b0;
    if (hit) begin
      check("hit_latency", 32'(fetcher_state), 32'(FETCHER_FETCHED));
      check("hit_no_request", 32'(mem_read_valid), 32'd0);
    end else begin
      core_state = 3'b000;
      check("miss_request", {28'd0, mem_read_valid, fetcher_state},
            {28'd0, 1'b1, 3'(FETCHER_FETCHING)});
      repeat (delay) @(negedge clk);
      check("miss_hold", {28'd0, mem_read_valid, fetcher_state},
            {28'd0, 1'b1, 3'(FETCHER_FETCHING)});
      mem_read_ready = 1'b1;
      mem_read_data  = mem[mem_read_address];
      invalidate     = inv_fill;
      @(negedge clk);
      mem_read_ready = 1'b0;
      invalidate     = 1'b0;
      mem_read_data  = 16'($urandom);
      check("miss_latency", {28'd0, mem_read_valid, fetcher_state},
            {28'd0, 1'b0, 3'(FETCHER_FETCHED)});
      if (inv_fill) model_clear();
      else begin
        m_valid[idx] = 1'b1;
        m_pc[idx]    = pc;
      end
    end
    core_state = CORE_DECODE;
    @(negedge clk);
    core_state = 3'b000;
    check("back_to_idle", 32'(fetcher_state), 32'(FETCHER_IDLE));
  endtask

  task automatic inv_pulse();
    @(negedge clk);
    invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
    model_clear();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; core_state = 3'b000; current_pc = '0; invalidate = 1'b0;
    mem_read_ready = 1'b0; mem_read_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h12] = 16'hBEEF;
    model_clear();
    m_hits = 0; m_misses = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
    check("reset_req", {mem_read_valid, mem_read_address}, 32'd0);
    check("reset_instr", 32'(instruction), 32'd0);
    check("reset_counts", {hit_count, miss_count}, 32'd0);
    check("reset_sat_counts", {28'd0, s_hit_count, s_miss_count}, 32'd0);

    // Cold miss, hit, conflict on the same index.
    do_fetch(8'h12, 1, 1'b0, 1'b0);
    do_fetch(8'h12, 0, 1'b0, 1'b0);
    do_fetch(8'h1A, 2, 1'b0, 1'b0);
    do_fetch(8'h12, 0, 1'b0, 1'b0);
    do_fetch(8'h12, 0, 1'b0, 1'b0);
    // Invalidate pulse, invalidate during lookup, invalidate during fill.
    inv_pulse();
    do_fetch(8'h12, 0, 1'b0, 1'b0);
    do_fetch(8'h12, 1, 1'b1, 1'b0);
    inv_pulse();
    do_fetch(8'h12, 1, 1'b0, 1'b1);
    do_fetch(8'h12, 0, 1'b0, 1'b0);

    // Reset while a miss is outstanding: request dropped, no fill.
    @(negedge clk);
    core_state = CORE_FETCH;
    current_pc = 8'h1A;
    addr_q.push_back(8'h1A);
    @(negedge clk);
    core_state = 3'b000;
    check("pre_reset_request", 32'(mem_read_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    m_hits = 0; m_misses = 0;
    check("midfetch_reset_state", {28'd0, mem_read_valid, fetcher_state},
          {28'd0, 1'b0, 3'(FETCHER_IDLE)});
    check("midfetch_reset_counts", {hit_count, miss_count}, 32'd0);
    do_fetch(8'h1A, 0, 1'b0, 1'b0);

    // Saturation of the 2-bit counters.
    do_fetch(8'h30, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) do_fetch(8'h30, 0, 1'b0, 1'b0);
    check("sat_hits_five", 32'(s_hit_count), 32'd3);
    check("wide_hits_five", 32'(hit_count), 32'd5);

    // Randomized traffic over a small pc range to force reuse and conflicts.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) inv_pulse();
      do_fetch(8'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    check("addr_queue_drained", 32'(addr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
